mem_block_mover: RTL

- Initiator-side engine that drives the single-port 256x8 memory array's write_enable/address/data_in and consumes its combinational data_out.
- Performs block FILL and block COPY (ascending or descending) on command from the CPU core, freeing the core from byte-by-byte loops.
- Sits between the core's control unit and the memory array port; the arbitration mux selects this block's memory outputs while busy=1.

---
 rtl/mem_block_mover.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_block_mover.sv
// mem_block_mover: memory FILL / COPY_UP / COPY_DOWN engine driving a single-port combinational-read RAM
module mem_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;
  state_t state, state_n;
  logic [1:0] mode_r, mode_n;
  logic [ADDR_W-1:0] src_r, src_n, dst_r, dst_n, off, off_n, step;
  logic [ADDR_W:0] cnt, cnt_n;
  logic [DATA_W-1:0] fill_r, fill_n, wdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic busy_n, done_n, error_n, we_n;
  assign step = (mode_r == 2'b10) ? off - 1'b1 : off + 1'b1;
  // Outputs are computed from the next state so that they appear registered in the cycle they describe.
  always_comb begin
    state_n = state;
    mode_n = mode_r;
    src_n = src_r;
    dst_n = dst_r;
    fill_n = fill_r;
    cnt_n = cnt;
    off_n = off;
    done_n = 1'b0;
    error_n = 1'b0;
    we_n = 1'b0;
    addr_n = '0;
    wdata_n = mem_wdata;
    case (state)
      IDLE: if (start) begin
        mode_n = mode;
        src_n = src_addr;
        dst_n = dst_addr;
        fill_n = fill_value;
        cnt_n = length;
        off_n = (mode == 2'b10) ? ADDR_W'(length - 1'b1) : '0;
        if (mode == 2'b11) error_n = 1'b1;
        else if (length == '0) begin
          state_n = FIN;
          done_n = 1'b1;
        end else if (mode == 2'b00) begin
          state_n = WRITE;
          we_n = 1'b1;
          addr_n = dst_addr;
          wdata_n = fill_value;
        end else begin
          state_n = READ;
          addr_n = src_addr + off_n;
        end
      end
      READ: begin
        state_n = WRITE;
        we_n = 1'b1;
        addr_n = dst_r + off;
        wdata_n = mem_rdata;
      end
      WRITE: begin
        cnt_n = cnt - 1'b1;
        off_n = step;
        if (cnt == (ADDR_W+1)'(1)) begin
          state_n = FIN;
          done_n = 1'b1;
        end else if (mode_r == 2'b00) begin
          we_n = 1'b1;
          addr_n = dst_r + step;
          wdata_n = fill_r;
        end else begin
          state_n = READ;
          addr_n = src_r + step;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == READ) || (state_n == WRITE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode_r <= '0;
      src_r <= '0;
      dst_r <= '0;
      fill_r <= '0;
      cnt <= '0;
      off <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      mode_r <= mode_n;
      src_r <= src_n;
      dst_r <= dst_n;
      fill_r <= fill_n;
      cnt <= cnt_n;
      off <= off_n;
      busy <= busy_n;
      done <= done_n;
      error <= error_n;
      mem_write_enable <= we_n;
      mem_address <= addr_n;
      mem_wdata <= wdata_n;
    end
  end
endmodule
